// File: rtl/shift_seq_pkg.sv
// Shared types and helpers for the shift_sequencer slice.
package shift_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;

    // LSB position of a lane inside a flattened multi-lane bus (input, ser or window).
    function automatic int lane_lsb(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/shift_lane.sv
// One N-bit lane: clear/load/shift register with runtime direction and output window.
// SHIFT_SEQ_ZERO_EXIT_EN enables the "becomes zero after this shift" detector.
module shift_lane
    import shift_seq_pkg::*;
#(
    parameter int N        = 16,
    parameter int OUT_BITS = N
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                clear,
    input  logic                load,
    input  logic                shift_en,
    input  logic                dir,
    input  logic [N-1:0]        load_data,
    output logic                ser_bit,
    output logic [OUT_BITS-1:0] window,
    output logic                next_zero
);

    logic [N-1:0] q;
    logic [N-1:0] shifted;

    always_comb begin
        shifted = (dir == DIR_LEFT) ? {q[N-2:0], 1'b0} : {1'b0, q[N-1:1]};
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q <= '0;
        end else if (clear) begin
            q <= '0;
        end else if (load) begin
            q <= load_data;
        end else if (shift_en) begin
            q <= shifted;
        end
    end

    assign ser_bit = (dir == DIR_LEFT) ? q[N-1] : q[0];
    assign window  = (dir == DIR_LEFT) ? q[N-1 -: OUT_BITS] : q[OUT_BITS-1:0];

`ifdef SHIFT_SEQ_ZERO_EXIT_EN
    assign next_zero = (shifted == '0);
`else
    assign next_zero = 1'b0;
`endif

endmodule

// File: rtl/shift_sequencer.sv
// CH-lane load/shift/hold sequencer with serial tap and parallel result window.
// SHIFT_SEQ_ZERO_EXIT_EN: leave SHIFT early once every lane has shifted to zero.
module shift_sequencer
    import shift_seq_pkg::*;
#(
    parameter int N        = 16,
    parameter int CH       = 4,
    parameter int OUT_BITS = N,
    parameter int CNT_W    = $clog2(N) + 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [CH*N-1:0]        in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   dir,
    input  logic [CNT_W-1:0]       num_shifts,
    input  logic                   clear,
    output logic [CH-1:0]          ser_out,
    output logic                   ser_valid,
    output logic [CH*OUT_BITS-1:0] out_data,
    output logic                   out_valid,
    input  logic                   out_ready
);

    state_e           state;
    state_e           state_next;
    logic [CNT_W-1:0] cnt;
    logic             dir_q;
    logic             load;
    logic             shift_en;
    logic             all_zero;
    logic [CH-1:0]    lane_ser;
    logic [CH-1:0]    lane_zero;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    assign all_zero = &lane_zero;

    // NOTE: every always_comb output is defaulted first so no path can infer a latch.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        shift_en   = 1'b0;
        in_ready   = 1'b0;
        ser_valid  = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load       = 1'b1;
                    state_next = (num_shifts != '0) ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                ser_valid = 1'b1;
                shift_en  = 1'b1;
                if (cnt == CNT_W'(1) || all_zero) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        // Abort overrides whatever the state asked for this cycle.
        if (clear) begin
            state_next = IDLE;
            load       = 1'b0;
            shift_en   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt   <= '0;
            dir_q <= DIR_RIGHT;
        end else if (clear) begin
            cnt   <= '0;
            dir_q <= DIR_RIGHT;
        end else if (load) begin
            cnt   <= num_shifts;
            dir_q <= dir;
        end else if (shift_en) begin
            cnt <= all_zero ? '0 : cnt - CNT_W'(1);
        end
    end

    for (genvar c = 0; c < CH; c++) begin : g_lane
        shift_lane #(
            .N        (N),
            .OUT_BITS (OUT_BITS)
        ) u_lane (
            .clk       (clk),
            .reset_n   (reset_n),
            .clear     (clear),
            .load      (load),
            .shift_en  (shift_en),
            .dir       (dir_q),
            .load_data (in_data[lane_lsb(c, N) +: N]),
            .ser_bit   (lane_ser[c]),
            .window    (out_data[lane_lsb(c, OUT_BITS) +: OUT_BITS]),
            .next_zero (lane_zero[c])
        );
    end

    // The serial tap only carries meaning while shifting; park it at zero otherwise.
    assign ser_out = lane_ser & {CH{ser_valid}};

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer (full-width and narrow-window instances).
module tb_shift_sequencer;

    localparam int N  = 8;
    localparam int CH = 2;
    localparam int CW = 4;
    localparam int OB = 5;

    logic          clk        = 1'b0;
    logic          reset_n    = 1'b0;
    logic [15:0]   in_data    = '0;
    logic          in_valid   = 1'b0;
    logic          dir        = 1'b0;
    logic [CW-1:0] num_shifts = '0;
    logic          clear      = 1'b0;
    logic          out_ready  = 1'b0;

    logic          in_ready,  in_ready_w;
    logic [1:0]    ser_out,   ser_out_w;
    logic          ser_valid, ser_valid_w;
    logic [15:0]   out_data;
    logic [9:0]    out_data_w;
    logic          out_valid, out_valid_w;

    int n_cmp = 0;
    int n_bad = 0;

    shift_sequencer #(.N(N), .CH(CH), .OUT_BITS(N), .CNT_W(CW)) dut (
        .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .dir(dir), .num_shifts(num_shifts), .clear(clear),
        .ser_out(ser_out), .ser_valid(ser_valid), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    shift_sequencer #(.N(N), .CH(CH), .OUT_BITS(OB), .CNT_W(CW)) dut_w (
        .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready_w), .dir(dir), .num_shifts(num_shifts), .clear(clear),
        .ser_out(ser_out_w), .ser_valid(ser_valid_w), .out_data(out_data_w),
        .out_valid(out_valid_w), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    // Reference model: a lane after k zero-filled shifts, and the bit leaving on shift i.
    function automatic int lane_after(input int v, input bit d, input int k);
        if (k >= N) return 0;
        return d ? ((v << k) & 255) : (v >> k);
    endfunction

    function automatic int leave_bit(input int v, input bit d, input int i);
        if (i >= N) return 0;
        return d ? ((v >> (N - 1 - i)) & 1) : ((v >> i) & 1);
    endfunction

    function automatic int win(input int v, input bit d);
        return d ? ((v >> (N - OB)) & 31) : (v & 31);
    endfunction

    function automatic int exp_dur(input int l0, input int l1, input bit d, input int ns);
`ifdef SHIFT_SEQ_ZERO_EXIT_EN
        for (int k = 1; k <= ns; k++)
            if (lane_after(l0, d, k) == 0 && lane_after(l1, d, k) == 0) return k;
`endif
        return ns;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Load one operation, follow it through SHIFT and DONE (held for 'hold' cycles), back to IDLE.
    task automatic run_op(input logic [15:0] data, input bit d, input int ns, input int hold);
        int l0, l1, dur, r0, r1;
        logic [1:0] es;
        l0  = int'(data[7:0]);
        l1  = int'(data[15:8]);
        dur = exp_dur(l0, l1, d, ns);
        r0  = lane_after(l0, d, dur);
        r1  = lane_after(l1, d, dur);
        check("idle_ready", {30'd0, in_ready_w, in_ready}, 32'd3);
        in_valid   = 1'b1;
        in_data    = data;
        dir        = d;
        num_shifts = CW'(ns);
        step();
        in_valid = 1'b0;
        for (int i = 0; i < dur; i++) begin
            es = {1'(leave_bit(l1, d, i)), 1'(leave_bit(l0, d, i))};
            check("shift_ser_valid", {30'd0, ser_valid_w, ser_valid}, 32'd3);
            check("shift_ser_out", {28'd0, ser_out_w, ser_out}, {28'd0, es, es});
            check("shift_out_valid", {30'd0, out_valid_w, out_valid}, 32'd0);
            check("shift_in_ready", {30'd0, in_ready_w, in_ready}, 32'd0);
            in_valid   = 1'($urandom);
            in_data    = 16'($urandom);
            dir        = 1'($urandom);
            num_shifts = CW'($urandom);
            out_ready  = 1'($urandom);
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        for (int h = 0; h <= hold; h++) begin
            check("done_out_valid", {30'd0, out_valid_w, out_valid}, 32'd3);
            check("done_ser_valid", {30'd0, ser_valid_w, ser_valid}, 32'd0);
            check("done_in_ready", {30'd0, in_ready_w, in_ready}, 32'd0);
            check("done_out_data", {16'd0, out_data}, 32'((r1 << 8) | r0));
            check("done_window", {22'd0, out_data_w}, 32'((win(r1, d) << OB) | win(r0, d)));
            if (h < hold) begin
                in_valid = 1'($urandom);
                in_data  = 16'($urandom);
            end else begin
                in_valid  = 1'b0;
                out_ready = 1'b1;
            end
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("back_idle_ready", {30'd0, in_ready_w, in_ready}, 32'd3);
        check("back_idle_valid", {30'd0, out_valid_w, out_valid}, 32'd0);
    endtask

    initial begin
        // Reset values while reset_n is held low.
        #3;
        check("rst_in_ready", {30'd0, in_ready_w, in_ready}, 32'd3);
        check("rst_out_valid", {30'd0, out_valid_w, out_valid}, 32'd0);
        check("rst_ser_valid", {30'd0, ser_valid_w, ser_valid}, 32'd0);
        check("rst_ser_out", {28'd0, ser_out_w, ser_out}, 32'd0);
        check("rst_out_data", {6'd0, out_data_w, out_data}, 32'd0);
        #9 reset_n = 1'b1;
        step();

        // Directed: right by 3, left by 1, zero shifts.
        run_op(16'h81F0, 1'b0, 3, 0);
        check("right3_lanes", {16'd0, out_data}, 32'h101E);
        run_op(16'h81F0, 1'b1, 1, 0);
        check("left1_lanes", {16'd0, out_data}, 32'h02E0);
        run_op(16'h81F0, 1'b0, 0, 0);
        check("zero_shift_lanes", {16'd0, out_data}, 32'h81F0);

        // Clear with two shifts still owed.
        in_valid   = 1'b1;
        in_data    = 16'hA5C3;
        dir        = 1'b0;
        num_shifts = 4'd4;
        step();
        in_valid = 1'b0;
        step();
        step();
        check("pre_clear_shifting", {31'd0, ser_valid}, 32'd1);
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("clear_in_ready", {30'd0, in_ready_w, in_ready}, 32'd3);
        check("clear_out_data", {6'd0, out_data_w, out_data}, 32'd0);
        check("clear_out_valid", {30'd0, out_valid_w, out_valid}, 32'd0);
        step();
        check("clear_stays_idle", {30'd0, out_valid_w, out_valid}, 32'd0);

        // Result held five cycles with ignored load pulses.
        run_op(16'h3C96, 1'b1, 2, 5);

        // Early-zero pattern and over-long shift counts.
        run_op(16'h0204, 1'b0, 7, 0);
        run_op(16'h0000, 1'b0, 5, 1);
        run_op(16'hFFFF, 1'b1, 12, 0);
        run_op(16'h8001, 1'b0, 15, 2);

        // Asynchronous reset in the middle of SHIFT.
        in_valid   = 1'b1;
        in_data    = 16'h7E5A;
        dir        = 1'b1;
        num_shifts = 4'd6;
        step();
        in_valid = 1'b0;
        step();
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_out_data", {6'd0, out_data_w, out_data}, 32'd0);
        check("async_rst_ser_valid", {30'd0, ser_valid_w, ser_valid}, 32'd0);
        check("async_rst_in_ready", {30'd0, in_ready_w, in_ready}, 32'd3);
        #3 reset_n = 1'b1;
        step();
        check("post_rst_out_valid", {30'd0, out_valid_w, out_valid}, 32'd0);

        // Randomized operations against the model.
        for (int t = 0; t < 30; t++) begin
            run_op(16'($urandom), 1'($urandom), int'($urandom_range(0, 15)),
                   int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
